rx_gearbox: RTL and testbench
=============================

RX_GEARBOX -- requirements
Module: rx_gearbox

Interface
REQ-001 SHALL: clk  input  1  receive word clock; all logic on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: din  input  32  serdes receive word; din[0] is the earliest received bit.
REQ-004 SHALL: din_ena  input  1  din valid this cycle.
REQ-005 SHALL: slip  input  1  single-cycle request to shift block alignment by one bit (from block sync).
REQ-006 SHALL: header  output  2  sync header of emitted block; header[0] is the first bit of the block.
REQ-007 SHALL: header_ena  output  1  one-cycle strobe, header and data valid.
REQ-008 SHALL: data  output  64  block payload; data[0] is the bit immediately after header[1].

Function
REQ-009 SHALL keep a bit buffer (at least 98 bits) and a fill count (7 bits, legal range 0..97); the oldest bit sits at position 0.
REQ-010 SHALL, on a din_ena cycle, form combined = buffer | (din << fill), with new fill = fill+32.
REQ-011 SHALL, if slip is pending on that din_ena cycle, drop combined bit 0 (combined >>= 1, fill -= 1) and clear the pending flag.
REQ-012 SHALL, if the resulting fill >= 66, extract combined[65:0] as one block: header = combined[1:0], data = combined[65:2]; buffer = combined >> 66; fill -= 66.
REQ-013 SHALL otherwise store combined unchanged with the resulting fill.
REQ-014 SHALL register header, data and header_ena: the block appears one cycle after the din_ena cycle that completes it.
REQ-015 SHALL emit at most one block per cycle; because 32 < 66, fill never exceeds 97 and no overflow handling exists.
REQ-016 SHALL hold header and data at their last values when header_ena = 0.
REQ-017 SHALL leave the buffer and fill unchanged on cycles with din_ena = 0, and emit nothing on those cycles.
REQ-018 SHALL sample slip into a pending flag; a slip at cycle t applies to the first din_ena cycle at or after t+1.
REQ-019 SHALL ignore a slip that arrives while the pending flag is already set (no accumulation).
REQ-020 SHALL, without slips and with continuous din_ena, emit exactly 16 blocks per 33 input words; the cadence is periodic.
REQ-021 SHALL make each slip delay the subsequent block stream by exactly one received bit relative to the no-slip stream.

Reset
REQ-022 SHALL on rst clear fill to 0, the buffer to 0, the pending flag to 0, header_ena to 0, header to 2'b00 and data to 0.
REQ-023 SHALL make rst dominate din_ena and slip in the same cycle.
REQ-024 SHALL discard any partial block when rst is asserted mid-operation; the first post-reset block starts at the first din bit after rst deasserts.

Structure
REQ-025 SHALL take WORD_W = 32, BLOCK_W = 66 and SH_W = 2 from the shared 10GBASE-R receive package, and shall not redefine them locally.
REQ-026 SHALL be a single module with no sub-modules; the buffer and fill logic are one always-block pipeline plus an output register stage.
REQ-027 SHALL connect header/header_ena directly to block sync and slip from its slp output; data passes to the descrambler.

Verification
REQ-028 SHALL cover: reset, then words 0,1,2 continuous -> first header_ena one cycle after word 2, fill afterwards 30.
REQ-029 SHALL cover: 33 continuous words of a serialized stream of 16 known 66-bit blocks -> 16 header_ena pulses with bit-exact header/data in order, fill back to 0.
REQ-030 SHALL cover: aligned stream offset by 5 bits, slip pulsed 5 times spaced 8 cycles -> later blocks all header 2'b01/2'b10 matching the source.
REQ-031 SHALL cover: slip on two consecutive cycles -> exactly one bit dropped.
REQ-032 SHALL cover: din_ena deasserted every other cycle -> identical block sequence, stretched in time, no header_ena on idle cycles.
REQ-033 SHALL cover: rst asserted with fill = 62 -> header_ena low next cycle, restart reproduces the REQ-028 timing.

Source files
------------

// File: rtl/rx_gearbox_pkg.sv
// rx_gearbox_pkg: shared 10GBASE-R receive widths used by the gearbox and its interface
package rx_gearbox_pkg;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 66;
  localparam int SH_W    = 2;
  localparam int DATA_W  = BLOCK_W - SH_W;
  localparam int BUF_W   = BLOCK_W + WORD_W;
  localparam int FILL_W  = 7;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/rx_gearbox_if.sv
// rx_gearbox_if: serdes word input, slip request and block output of the receive gearbox
interface rx_gearbox_if;
  import rx_gearbox_pkg::*;
  logic [WORD_W-1:0] din;
  logic              din_ena;
  logic              slip;
  logic [SH_W-1:0]   header;
  logic              header_ena;
  logic [DATA_W-1:0] data;
  modport master (output din, din_ena, slip, input header, header_ena, data);
  modport slave  (input din, din_ena, slip, output header, header_ena, data);
endinterface

// File: rtl/rx_gearbox.sv
// rx_gearbox: 32-bit serdes words to 66-bit blocks, with single-bit slip for block alignment
module rx_gearbox
  import rx_gearbox_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rx_gearbox_if.slave rx
);
  logic [BUF_W-1:0]  buf_q, buf_d, comb, shifted;
  logic [FILL_W-1:0] fill_q, fill_d, nfill;
  logic              pend_q, pend_d, emit;
  logic              hena_q;
  logic [SH_W-1:0]   hdr_q;
  logic [DATA_W-1:0] data_q;
  // fill never exceeds 65 between words, so the shifted word always fits in BUF_W
  always_comb begin
    comb    = buf_q | ({{(BUF_W-WORD_W){1'b0}}, rx.din} << fill_q);
    shifted = pend_q ? comb >> 1 : comb;
    nfill   = fill_q + FILL_W'(WORD_W) - FILL_W'(pend_q);
    emit    = rx.din_ena && nfill >= FILL_W'(BLOCK_W);
    buf_d   = !rx.din_ena ? buf_q : emit ? shifted >> BLOCK_W : shifted;
    fill_d  = !rx.din_ena ? fill_q : emit ? nfill - FILL_W'(BLOCK_W) : nfill;
    pend_d  = pend_q ? !rx.din_ena : rx.slip;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      hena_q <= 1'b0;
      hdr_q  <= '0;
      data_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      pend_q <= pend_d;
      hena_q <= emit;
      if (emit) begin
        hdr_q  <= shifted[SH_W-1:0];
        data_q <= shifted[BLOCK_W-1:SH_W];
      end
    end
  end
  assign rx.header     = hdr_q;
  assign rx.header_ena = hena_q;
  assign rx.data       = data_q;
endmodule

// File: tb/tb_rx_gearbox.sv
// tb_rx_gearbox: table vectors, known-block streams and random traffic against a bit-queue model
module tb_rx_gearbox;
  import rx_gearbox_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rx_gearbox_if bus ();
  rx_gearbox dut (.clk(clk), .rst(rst), .rx(bus));
  typedef struct {
    logic        r;
    logic [31:0] d;
    logic        e;
    logic        s;
    logic        x_ena;
    block_t      x_blk;
    logic        chk_blk;
  } vec_t;
  vec_t tv[7];
  int checks = 0, errors = 0;
  logic mq[$];
  logic m_pend, m_ena;
  logic [1:0] m_hdr;
  logic [63:0] m_data;
  block_t got[$];
  block_t src[$];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // bit-serial view: a queue of received bits, 66 popped per block, slip pops one
  task automatic model(input logic r, input logic [31:0] d, input logic e, input logic s);
    block_t b;
    if (r) begin
      mq.delete();
      m_pend = 1'b0;
      m_ena  = 1'b0;
      m_hdr  = '0;
      m_data = '0;
    end else begin
      m_ena = 1'b0;
      if (e) begin
        for (int i = 0; i < 32; i++) mq.push_back(d[i]);
        if (m_pend) void'(mq.pop_front());
        if (mq.size() >= 66) begin
          for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
          m_ena  = 1'b1;
          m_hdr  = b[1:0];
          m_data = b[65:2];
        end
      end
      m_pend = m_pend ? !e : s;
    end
  endtask
  task automatic step(input logic r, input logic [31:0] d, input logic e, input logic s);
    rst = r;
    bus.din = d;
    bus.din_ena = e;
    bus.slip = s;
    model(r, d, e, s);
    @(posedge clk);
    #1;
    chk("model_ena", 128'(bus.header_ena), 128'(m_ena));
    chk("model_hdr", 128'(bus.header), 128'(m_hdr));
    chk("model_data", 128'(bus.data), 128'(m_data));
    if (bus.header_ena) got.push_back({bus.data, bus.header});
  endtask
  task automatic apply_rows(input int lo);
    for (int i = lo; i < 7; i++) begin
      step(tv[i].r, tv[i].d, tv[i].e, tv[i].s);
      chk($sformatf("tv%0d_ena", i), 128'(bus.header_ena), 128'(tv[i].x_ena));
      if (tv[i].chk_blk) chk($sformatf("tv%0d_blk", i), 128'({bus.data, bus.header}), 128'(tv[i].x_blk));
    end
  endtask
  task automatic make_src(input int n);
    src.delete();
    for (int k = 0; k < n; k++) src.push_back({$urandom, $urandom, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10});
  endtask
  task automatic run_stream(input int junk, input int nwords, input int slip_first, input int slip_gap,
                            input int nslips, input bit gaps);
    logic bits[$];
    logic [31:0] d;
    int rel;
    logic s;
    step(1'b1, 32'h0, 1'b0, 1'b0);
    got.delete();
    for (int i = 0; i < junk; i++) bits.push_back(1'($urandom));
    foreach (src[k]) for (int i = 0; i < 66; i++) bits.push_back(src[k][i]);
    for (int w = 0; w < nwords; w++) begin
      for (int i = 0; i < 32; i++) d[i] = (bits.size() > 0) ? bits.pop_front() : 1'($urandom);
      rel = w - slip_first;
      s = nslips > 0 && rel >= 0 && rel % slip_gap == 0 && rel / slip_gap < nslips;
      step(1'b0, d, 1'b1, s);
      if (gaps) begin
        step(1'b0, $urandom, 1'b0, 1'b0);
        chk("idle_ena", 128'(bus.header_ena), 128'(0));
      end
    end
  endtask
  task automatic cmp_blocks(input string name, input int first, input int expect_n);
    chk({name, "_count"}, 128'(got.size()), 128'(expect_n));
    for (int k = first; k < expect_n && k < got.size(); k++) chk($sformatf("%s_blk%0d", name, k), 128'(got[k]), 128'(src[k]));
  endtask
  initial begin
    logic [31:0] w[5];
    logic [159:0] s;
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    s = {w[4], w[3], w[2], w[1], w[0]};
    tv[0] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, '0, 1'b1};
    tv[1] = '{1'b0, w[0], 1'b1, 1'b0, 1'b0, '0, 1'b0};
    tv[2] = '{1'b0, w[1], 1'b1, 1'b0, 1'b0, '0, 1'b0};
    tv[3] = '{1'b0, w[2], 1'b1, 1'b0, 1'b1, s[65:0], 1'b1};
    tv[4] = '{1'b0, ~w[3], 1'b0, 1'b0, 1'b0, s[65:0], 1'b1};
    tv[5] = '{1'b0, w[3], 1'b1, 1'b0, 1'b0, '0, 1'b0};
    tv[6] = '{1'b0, w[4], 1'b1, 1'b0, 1'b1, s[131:66], 1'b1};
    rst = 1'b1;
    bus.din = '0;
    bus.din_ena = 1'b0;
    bus.slip = 1'b0;
    apply_rows(0);
    // reset with 62 bits buffered: the pending block must never appear
    step(1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, w[i], 1'b1, 1'b0);
    step(1'b1, w[4], 1'b1, 1'b1);
    chk("rst_dom_ena", 128'(bus.header_ena), 128'(0));
    apply_rows(1);
    make_src(16);
    run_stream(0, 33, 0, 1, 0, 1'b0);
    cmp_blocks("aligned", 0, 16);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, 1'b1, 1'b0);
      chk($sformatf("refill%0d_ena", i), 128'(bus.header_ena), 128'(i == 2));
    end
    make_src(16);
    run_stream(0, 33, 0, 1, 0, 1'b1);
    cmp_blocks("gapped", 0, 16);
    make_src(32);
    run_stream(5, 67, 1, 8, 5, 1'b0);
    cmp_blocks("slip5", 20, 32);
    for (int k = 20; k < 32 && k < got.size(); k++)
      chk($sformatf("slip5_hdr%0d", k), 128'(got[k][1:0] == 2'b01 || got[k][1:0] == 2'b10), 128'(1));
    make_src(8);
    run_stream(1, 17, 0, 1, 2, 1'b0);
    cmp_blocks("dblslip", 0, 8);
    for (int c = 0; c < 3000; c++)
      step(1'(($urandom % 100) == 0), $urandom, 1'(($urandom % 4) != 0), 1'(($urandom % 8) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
